sdram_port_arbiter: RTL and testbench

Shares the single command/read port of `SDRAM_Controller_v` between two requesters: port 0 (acquisition writer, sampler path) and port 1 (readback/serial dump path). It serialises commands, routes each read return to the port that issued it, and bounds read waits with a timeout. It sits on `clk100` between the main control FSMs and the SDRAM controller.

---
 rtl/sdram_port_arbiter.sv | 174 +++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// Two-port command arbiter in front of the SDRAM controller command/read port.
// Define SDRAM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module sdram_port_arbiter #(
    parameter int ADDR_W     = 23,
    parameter int DATA_W     = 32,
    parameter int RD_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_wr,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_rvalid,
    output logic              p0_rerr,
    input  logic              p1_req,
    input  logic              p1_wr,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_rvalid,
    output logic              p1_rerr,
    input  logic              mem_ready,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic [1:0]        owner
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(RD_TIMEOUT);

    state_t     state_r;
    logic [7:0] rd_cnt_r;
    logic       elig0_s;
    logic       elig1_s;
    logic       winner_s;
`ifdef SDRAM_ARB_RR_EN
    logic       last_r;
`endif

    // Eligibility and winner selection; a request acked this cycle is not re-granted.
    always_comb begin
        elig0_s = p0_req & ~p0_ack;
        elig1_s = p1_req & ~p1_ack;
`ifdef SDRAM_ARB_RR_EN
        if (elig0_s && elig1_s) begin
            winner_s = ~last_r;
        end else if (elig0_s) begin
            winner_s = 1'b0;
        end else begin
            winner_s = 1'b1;
        end
`else
        if (elig0_s) begin
            winner_s = 1'b0;
        end else begin
            winner_s = 1'b1;
        end
`endif
    end

    // Arbitration FSM with registered controller and port outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            rd_cnt_r   <= 8'd0;
            mem_enable <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= {ADDR_W{1'b0}};
            mem_wdata  <= {DATA_W{1'b0}};
            owner      <= 2'b00;
            p0_ack     <= 1'b0;
            p1_ack     <= 1'b0;
            p0_rvalid  <= 1'b0;
            p1_rvalid  <= 1'b0;
            p0_rerr    <= 1'b0;
            p1_rerr    <= 1'b0;
            p0_rdata   <= {DATA_W{1'b0}};
            p1_rdata   <= {DATA_W{1'b0}};
`ifdef SDRAM_ARB_RR_EN
            last_r     <= 1'b1;
`endif
        end else begin
            p0_ack    <= 1'b0;
            p1_ack    <= 1'b0;
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            p0_rerr   <= 1'b0;
            p1_rerr   <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (elig0_s || elig1_s) begin
                        state_r    <= ISSUE;
                        mem_enable <= 1'b1;
                        if (winner_s == 1'b0) begin
                            mem_wr    <= p0_wr;
                            mem_addr  <= p0_addr;
                            mem_wdata <= p0_wdata;
                            owner     <= 2'b01;
                        end else begin
                            mem_wr    <= p1_wr;
                            mem_addr  <= p1_addr;
                            mem_wdata <= p1_wdata;
                            owner     <= 2'b10;
                        end
`ifdef SDRAM_ARB_RR_EN
                        last_r <= winner_s;
`endif
                    end
                end
                ISSUE: begin
                    if (mem_ready) begin
                        mem_enable <= 1'b0;
                        p0_ack     <= owner[0];
                        p1_ack     <= owner[1];
                        if (mem_wr) begin
                            state_r <= IDLE;
                            owner   <= 2'b00;
                        end else begin
                            state_r  <= WAIT_RD;
                            rd_cnt_r <= 8'd0;
                        end
                    end
                end
                WAIT_RD: begin
                    // Returned data takes precedence over a timeout in the same cycle.
                    if (mem_rvalid) begin
                        if (owner[0]) begin
                            p0_rdata  <= mem_rdata;
                            p0_rvalid <= 1'b1;
                        end else begin
                            p1_rdata  <= mem_rdata;
                            p1_rvalid <= 1'b1;
                        end
                        state_r <= IDLE;
                        owner   <= 2'b00;
                    end else if (rd_cnt_r == TIMEOUT_C) begin
                        if (owner[0]) begin
                            p0_rdata  <= {DATA_W{1'b0}};
                            p0_rvalid <= 1'b1;
                            p0_rerr   <= 1'b1;
                        end else begin
                            p1_rdata  <= {DATA_W{1'b0}};
                            p1_rvalid <= 1'b1;
                            p1_rerr   <= 1'b1;
                        end
                        state_r <= IDLE;
                        owner   <= 2'b00;
                    end else begin
                        rd_cnt_r <= rd_cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    mem_enable <= 1'b0;
                    owner      <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Randomized self-checking bench for sdram_port_arbiter against a transaction-level model.
module tb_sdram_port_arbiter;
    localparam int AW = 23;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          p0_req, p0_wr, p1_req, p1_wr;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic          p0_ack, p1_ack, p0_rvalid, p1_rvalid, p0_rerr, p1_rerr;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic          mem_ready, mem_enable, mem_wr, mem_rvalid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [1:0]    owner;

    always #5 clk = ~clk;

    sdram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_wr(p0_wr), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_rvalid(p0_rvalid), .p0_rerr(p0_rerr),
        .p1_req(p1_req), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_rvalid(p1_rvalid), .p1_rerr(p1_rerr),
        .mem_ready(mem_ready), .mem_enable(mem_enable), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_rvalid(mem_rvalid), .owner(owner)
    );

    int errors = 0;
    int checks = 0;

    // Model: pending command per port, ack-just-seen flags, last grant, held read data.
    logic          pv[2];
    logic          pwr[2];
    logic [AW-1:0] paddr[2];
    logic [DW-1:0] pwd[2];
    logic          acked_now[2];
    logic [DW-1:0] exp_rdata[2];
`ifdef SDRAM_ARB_RR_EN
    logic          last_gnt;
`endif

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ports();
        p0_req = pv[0]; p0_wr = pwr[0]; p0_addr = paddr[0]; p0_wdata = pwd[0];
        p1_req = pv[1]; p1_wr = pwr[1]; p1_addr = paddr[1]; p1_wdata = pwd[1];
    endtask

    task automatic new_cmd(input int p, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        pv[p] = 1'b1; pwr[p] = wr; paddr[p] = a; pwd[p] = d;
        drive_ports();
    endtask

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            pv[p] = 1'b0; pwr[p] = 1'b0; paddr[p] = '0; pwd[p] = '0;
            acked_now[p] = 1'b0; exp_rdata[p] = '0;
        end
`ifdef SDRAM_ARB_RR_EN
        last_gnt = 1'b1;
`endif
        drive_ports();
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ctl"}, {mem_enable, mem_wr, p0_ack, p1_ack, p0_rvalid, p1_rvalid,
                                 p0_rerr, p1_rerr, owner}, 64'd0);
        check_eq({tag, "_addr"}, 64'(mem_addr), 64'd0);
        check_eq({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
        check_eq({tag, "_rdata"}, {p0_rdata, p1_rdata}, 64'd0);
    endtask

    function automatic int pick_winner(input logic e0, input logic e1);
        if (e0 && e1) begin
`ifdef SDRAM_ARB_RR_EN
            return last_gnt ? 0 : 1;
`else
            return 0;
`endif
        end
        return e0 ? 0 : 1;
    endfunction

    // One full command: grant, optional ready stall, acceptance, and read completion.
    task automatic run_cmd(input int stall, input int lat, input logic [DW-1:0] rd_val, input logic refill);
        int w, resp;
        logic e0, e1, wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        e0 = pv[0] && !acked_now[0];
        e1 = pv[1] && !acked_now[1];
        if (!e0 && !e1) begin
            step();
            check_eq("no_regrant", 64'(mem_enable), 64'd0);
            acked_now[0] = 1'b0; acked_now[1] = 1'b0;
            e0 = pv[0]; e1 = pv[1];
        end
        w = pick_winner(e0, e1);
        wr = pwr[w]; a = paddr[w]; d = pwd[w];
        mem_ready = 1'b0;
        step();
        check_eq("grant_en", 64'(mem_enable), 64'd1);
        check_eq("grant_owner", 64'(owner), 64'(2'b01 << w));
        check_eq("grant_wr", 64'(mem_wr), 64'(wr));
        check_eq("grant_addr", 64'(mem_addr), 64'(a));
        check_eq("grant_wdata", 64'(mem_wdata), 64'(d));
        check_eq("grant_noack", {p0_ack, p1_ack}, 64'd0);
        for (int i = 0; i < stall; i++) begin
            step();
            check_eq("stall_en", 64'(mem_enable), 64'd1);
            check_eq("stall_fields", {mem_wr, mem_addr, mem_wdata}, {wr, a, d});
            check_eq("stall_noack", {p0_ack, p1_ack, owner}, {2'b00, 2'(2'b01 << w)});
        end
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        check_eq("ack_pulse", {p0_ack, p1_ack}, (w == 0) ? 64'd2 : 64'd1);
        check_eq("ack_en_low", 64'(mem_enable), 64'd0);
`ifdef SDRAM_ARB_RR_EN
        last_gnt = w[0];
`endif
        pv[w] = 1'b0;
        acked_now[w] = 1'b1;
        acked_now[1-w] = 1'b0;
        if (refill && $urandom_range(0, 1) == 1)
            new_cmd(w, 1'($urandom_range(0, 1)), AW'($urandom), $urandom);
        else
            drive_ports();
        if (wr) begin
            check_eq("wr_owner_clr", 64'(owner), 64'd0);
        end else begin
            resp = (lat <= TO) ? lat + 1 : TO + 1;
            for (int s = 0; s < resp; s++) begin
                mem_rvalid = (s == lat);
                mem_rdata = (s == lat) ? rd_val : $urandom;
                step();
                mem_rvalid = 1'b0;
                check_eq("rd_no_grant", 64'(mem_enable), 64'd0);
                if (s + 1 < resp) begin
                    check_eq("rd_wait_quiet", {p0_rvalid, p1_rvalid}, 64'd0);
                end else begin
                    exp_rdata[w] = (lat <= TO) ? rd_val : '0;
                    check_eq("rd_rvalid", {p0_rvalid, p1_rvalid}, (w == 0) ? 64'd2 : 64'd1);
                    check_eq("rd_rerr", {p0_rerr, p1_rerr},
                             (lat <= TO) ? 64'd0 : ((w == 0) ? 64'd2 : 64'd1));
                    check_eq("rd_p0_rdata", 64'(p0_rdata), 64'(exp_rdata[0]));
                    check_eq("rd_p1_rdata", 64'(p1_rdata), 64'(exp_rdata[1]));
                    check_eq("rd_owner_clr", 64'(owner), 64'd0);
                end
            end
            acked_now[0] = 1'b0; acked_now[1] = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        model_reset();
        step();
        step();
        check_all_zero("reset");
        rst = 1'b1;
        step();

        // Single p0 write, controller ready immediately.
        new_cmd(0, 1'b1, 23'h000010, 32'hDEADBEEF);
        run_cmd(0, 0, 32'h0, 1'b0);

        // p1 read of top address, data after 9 cycles.
        new_cmd(1, 1'b0, 23'h7FFFFF, 32'h0);
        run_cmd(0, 9, 32'h12345678, 1'b0);

        // Simultaneous requests, each port re-presenting commands as it is acked.
        new_cmd(0, 1'b1, 23'h000100, 32'hA0A0A0A0);
        new_cmd(1, 1'b1, 23'h000200, 32'hB0B0B0B0);
        for (int k = 0; k < 8; k++) begin
            if (!pv[0] && k < 6) new_cmd(0, 1'b1, AW'(23'h000100 + k), 32'hA0000000 + k);
            if (!pv[1] && k < 6) new_cmd(1, 1'b1, AW'(23'h000200 + k), 32'hB0000000 + k);
            if (pv[0] || pv[1]) run_cmd(0, 0, 32'h0, 1'b0);
        end

        // Controller busy for 20 cycles.
        if (!pv[0] && !pv[1]) new_cmd(1, 1'b1, 23'h0ABCDE, 32'h55AA55AA);
        run_cmd(20, 0, 32'h0, 1'b0);
        while (pv[0] || pv[1]) run_cmd(0, 0, 32'h0, 1'b0);

        // Read timeout followed by late data that must be ignored.
        new_cmd(0, 1'b0, 23'h001234, 32'h0);
        run_cmd(0, TO + 3, 32'h0, 1'b0);
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
        step();
        mem_rvalid = 1'b0;
        check_eq("late_ignored", {p0_rvalid, p1_rvalid, mem_enable}, 64'd0);
        check_eq("late_rdata", 64'(p0_rdata), 64'(exp_rdata[0]));

        // Reset in the middle of a read wait, then late data after release.
        new_cmd(0, 1'b0, 23'h000777, 32'h0);
        step();
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        pv[0] = 1'b0; drive_ports();
        step();
        step();
        #2 rst = 1'b0;
        #1 check_all_zero("rst_wait");
        step();
        rst = 1'b1;
        model_reset();
        mem_rvalid = 1'b1; mem_rdata = 32'h87654321;
        step();
        mem_rvalid = 1'b0;
        check_eq("post_rst_rvalid", {p0_rvalid, p1_rvalid}, 64'd0);
        check_eq("post_rst_rdata", {p0_rdata, p1_rdata}, 64'd0);

        // Reset while a command is being issued drops mem_enable immediately.
        new_cmd(1, 1'b1, 23'h000042, 32'h11223344);
        step();
        check_eq("issue_en", 64'(mem_enable), 64'd1);
        #2 rst = 1'b0;
        #1 check_eq("rst_issue_en", {mem_enable, owner}, 64'd0);
        step();
        rst = 1'b1;
        model_reset();
        step();
        new_cmd(0, 1'b1, 23'h000099, 32'h0BADF00D);
        run_cmd(1, 0, 32'h0, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 80; n++) begin
            for (int p = 0; p < 2; p++)
                if (!pv[p] && $urandom_range(0, 9) < 6)
                    new_cmd(p, 1'($urandom_range(0, 1)), AW'($urandom), $urandom);
            if (!pv[0] && !pv[1])
                new_cmd(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom), $urandom);
            run_cmd(int'($urandom_range(0, 3)), int'($urandom_range(0, TO + 3)), $urandom, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
